muldiv_cmd_seq: RTL and testbench

//   Upstream command front-end for the HI/LO multiply/divide core. Debounces one raw push

---
 rtl/muldiv_cmd_seq.sv | 80 ++++++++
 tb/tb_muldiv_cmd_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_cmd_seq.sv
// muldiv_cmd_seq: debounced push-button entry of A, B and function code for the HI/LO muldiv core.
// Optional MULDIV_CMD_DIVZERO_GUARD_EN suppresses divide issue when b==0 and raises sticky err.
module muldiv_cmd_seq #(
  parameter int N          = 3,
  parameter int DEB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_raw,
  input  logic [N-1:0] sw_val,
  input  logic [3:0]   sw_f,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic [3:0]   f,
  output logic         issue,
  output logic [1:0]   step,
  output logic         err
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  localparam logic [1:0] S_A = 2'd0, S_B = 2'd1, S_F = 2'd2, S_ISSUE = 2'd3;
  logic          sync1_q, sync2_q, stable_q, stable_d, press, fire, blocked;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [3:0]    f_q, f_d, view_q, view_d;
  logic          err_q, err_d;
  always_comb begin
    stable_d = (sync2_q != stable_q && cnt_q == LAST) ? sync2_q : stable_q;
    cnt_d    = (sync2_q == stable_q || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    press    = stable_d & ~stable_q;
  end
  always_comb begin
    fire    = state_q == S_ISSUE;
`ifdef MULDIV_CMD_DIVZERO_GUARD_EN
    blocked = fire && f_q == 4'b1010 && b_q == '0;
    err_d   = blocked | (err_q & ~issue);
`else
    blocked = 1'b0;
    err_d   = 1'b0;
`endif
    issue   = fire & ~blocked;
    state_d = fire ? S_A : (press ? state_q + 2'd1 : state_q);
    a_d     = (press && state_q == S_A) ? sw_val : a_q;
    b_d     = (press && state_q == S_B) ? sw_val : b_q;
    f_d     = (press && state_q == S_F) ? sw_f : f_q;
    // Only non-writing codes are safe to leave on the F bus while idle.
    view_d  = (issue && (f_q == 4'b0000 || f_q == 4'b0010)) ? f_q : view_q;
    f       = issue ? f_q : view_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      f_q      <= 4'b0000;
      view_q   <= 4'b0000;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      f_q      <= f_d;
      view_q   <= view_d;
      err_q    <= err_d;
    end
  end
  assign a    = a_q;
  assign b    = b_q;
  assign step = state_q;
  assign err  = err_q;
endmodule

// File: tb/tb_muldiv_cmd_seq.sv
// tb_muldiv_cmd_seq: directed table-driven bench for muldiv_cmd_seq with DEB_CYCLES=4.
module tb_muldiv_cmd_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic [2:0] sw_val = '0;
  logic [3:0] sw_f = '0;
  logic [2:0] a, b;
  logic [3:0] f;
  logic       issue, err;
  logic [1:0] step;
  int n_cmp = 0, n_bad = 0;

  muldiv_cmd_seq #(.N(3), .DEB_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_val(sw_val), .sw_f(sw_f),
    .a(a), .b(b), .f(f), .issue(issue), .step(step), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] va, vb;
    logic [3:0] vf;
    logic       exp_issue;
    logic [3:0] exp_f, exp_view;
    logic       exp_err;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(output int cyc);
    logic [1:0] s0;
    s0 = step;
    btn_raw = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (step !== s0) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic release_btn();
    btn_raw = 1'b0;
    tick(8);
  endtask

  task automatic do_reset();
    btn_raw = 1'b0;
    #2 rst_n = 1'b0;
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [3:0] view_prev;
    tbl[0] = '{3'd3, 3'd2, 4'b1000, 1'b1, 4'b1000, 4'b0000, 1'b0};
    tbl[1] = '{3'd1, 3'd1, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b0};
    tbl[2] = '{3'd5, 3'd7, 4'b0001, 1'b1, 4'b0001, 4'b0010, 1'b0};
`ifdef MULDIV_CMD_DIVZERO_GUARD_EN
    tbl[3] = '{3'd6, 3'd0, 4'b1010, 1'b0, 4'b0010, 4'b0010, 1'b1};
`else
    tbl[3] = '{3'd6, 3'd0, 4'b1010, 1'b1, 4'b1010, 4'b0010, 1'b0};
`endif
    tbl[4] = '{3'd4, 3'd2, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0};
    tbl[5] = '{3'd2, 3'd3, 4'b0011, 1'b1, 4'b0011, 4'b0000, 1'b0};
    tbl[6] = '{3'd7, 3'd5, 4'b0111, 1'b1, 4'b0111, 4'b0000, 1'b0};

    do_reset();
    chk("rst_a", 8'(a), 0);
    chk("rst_b", 8'(b), 0);
    chk("rst_f", 8'(f), 0);
    chk("rst_issue", 8'(issue), 0);
    chk("rst_step", 8'(step), 0);
    chk("rst_err", 8'(err), 0);

    // clean press latency: 2 sync + 4 debounce cycles
    sw_val = 3'd3;
    press(cyc);
    chk("latency", 8'(cyc), 6);
    chk("lat_a", 8'(a), 3);
    release_btn();
    // 3-cycle glitch is rejected
    btn_raw = 1'b1;
    tick(3);
    btn_raw = 1'b0;
    tick(12);
    chk("glitch_step", 8'(step), 1);
    // bounce 1010 then steady high gives one advance
    sw_val = 3'd6;
    foreach (tbl[0].va[i]) begin end
    btn_raw = 1'b1; tick(1);
    btn_raw = 1'b0; tick(1);
    btn_raw = 1'b1; tick(1);
    btn_raw = 1'b0; tick(1);
    btn_raw = 1'b1;
    tick(10);
    chk("bounce_step", 8'(step), 2);
    chk("bounce_b", 8'(b), 6);
    release_btn();
    chk("bounce_rel_step", 8'(step), 2);

    // reset in the middle of an entry
    do_reset();
    sw_val = 3'd5;
    press(cyc);
    release_btn();
    chk("mid_step", 8'(step), 1);
    chk("mid_a", 8'(a), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a", 8'(a), 0);
    chk("arst_step", 8'(step), 0);
    chk("arst_f", 8'(f), 0);
    chk("arst_issue", 8'(issue), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    sw_val = 3'd2;
    press(cyc);
    chk("post_rst_step", 8'(step), 1);
    chk("post_rst_a", 8'(a), 2);
    chk("post_rst_b", 8'(b), 0);
    release_btn();

    do_reset();
    view_prev = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      sw_val = tbl[i].va;
      press(cyc);
      chk($sformatf("v%0d_lat", i), 8'(cyc), 6);
      chk($sformatf("v%0d_a", i), 8'(a), 8'(tbl[i].va));
      release_btn();
      sw_val = tbl[i].vb;
      press(cyc);
      chk($sformatf("v%0d_stepB", i), 8'(step), 2);
      chk($sformatf("v%0d_b", i), 8'(b), 8'(tbl[i].vb));
      release_btn();
      chk($sformatf("v%0d_f_before", i), 8'(f), 8'(view_prev));
      chk($sformatf("v%0d_issue_before", i), 8'(issue), 0);
      sw_f = tbl[i].vf;
      sw_val = 3'd0;
      press(cyc);
      chk($sformatf("v%0d_stepI", i), 8'(step), 3);
      chk($sformatf("v%0d_issue", i), 8'(issue), 8'(tbl[i].exp_issue));
      chk($sformatf("v%0d_f_issue", i), 8'(f), 8'(tbl[i].exp_f));
      chk($sformatf("v%0d_a_issue", i), 8'(a), 8'(tbl[i].va));
      chk($sformatf("v%0d_b_issue", i), 8'(b), 8'(tbl[i].vb));
      tick(1);
      chk($sformatf("v%0d_step_after", i), 8'(step), 0);
      chk($sformatf("v%0d_issue_after", i), 8'(issue), 0);
      chk($sformatf("v%0d_f_after", i), 8'(f), 8'(tbl[i].exp_view));
      chk($sformatf("v%0d_err", i), 8'(err), 8'(tbl[i].exp_err));
      chk($sformatf("v%0d_a_held", i), 8'(a), 8'(tbl[i].va));
      release_btn();
      chk($sformatf("v%0d_f_idle", i), 8'(f), 8'(tbl[i].exp_view));
      chk($sformatf("v%0d_err_idle", i), 8'(err), 8'(tbl[i].exp_err));
      view_prev = tbl[i].exp_view;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
